h_fwd_ctrl: RTL and testbench
=============================

H_FWD_CTRL -- requirements
Module: h_fwd_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, is the number of consecutive memory-wait cycles before error.
REQ-002 Parameter REG_AW, default 5, is the register address width.
REQ-003 Port clk, input, 1: single clock; all state on rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Ports i_data_rs1D and i_data_rs2D, input, REG_AW each: D-stage source registers.
REQ-006 Port i_data_rdD, input, REG_AW: D-stage destination register.
REQ-007 Ports i_con_regwriteD and i_con_loadD, input, 1 each: D-stage writes rd; D-stage instruction is a load.
REQ-008 Port i_con_pcsrcE, input, 1: branch/jump taken in E.
REQ-009 Port i_con_memready, input, 1: data memory completes the M-stage load this cycle.
REQ-010 Ports o_con_fa and o_con_fb, output, 2 each: E-stage operand select (00 rs, 01 writeback result, 10 M ALU result, 11 M memory out).
REQ-011 Ports o_con_stallF, o_con_stallD, o_con_stallE, o_con_stallM, o_con_stallW, o_con_flushD, o_con_flushE, output, 1 each: pipeline controls.
REQ-012 Port o_con_memerr, output, 1: sticky memory-timeout flag.

Function
REQ-013 Internal tag slices E, M and W each hold {rs1, rs2, rd, regwrite, load}; D inputs advance D->E->M->W every unstalled cycle.
REQ-014 o_con_fa is combinational from the E tag: 10 if M.regwrite, M.rd==E.rs1, M.rd!=0 and !M.load; 11 if the same match holds with M.load; else 01 if W.regwrite, W.rd==E.rs1, W.rd!=0; else 00. o_con_fb is computed the same way from E.rs2.
REQ-015 M match has priority over W match; register x0 never forwards.
REQ-016 Memory wait: when M.load && !i_con_memready, all five stall outputs are 1, every tag holds, and flushes are 0.
REQ-017 Taken branch: i_con_pcsrcE with no memory wait asserts o_con_flushD and o_con_flushE for one cycle; the E tag loads a bubble (regwrite=0, load=0).
REQ-018 Memory wait dominates i_con_pcsrcE; the CPU holds pcsrcE stable until the wait ends.
REQ-019 A wait counter increments each memory-wait cycle and clears on any non-wait cycle; reaching MEM_TIMEOUT sets o_con_memerr, which clears only on rst.
REQ-020 The counter saturates at MEM_TIMEOUT; the stall continues until i_con_memready.

Reset
REQ-021 On rst, all tags clear to bubble (rd=0, regwrite=0, load=0), the counter clears to 0 and o_con_memerr goes to 0.
REQ-022 After rst, fa and fb read 00 and all stall/flush outputs read 0; rst during a stall aborts the stall immediately.

Configuration
REQ-023 With macro H_FWD_MEMOUT_EN defined, the select 11 (load data from M) is used and no load-use stall exists.
REQ-024 Without it, select 11 is never produced. A load-use hazard (E.load, E.rd!=0, E.rd matching rs1D or rs2D) asserts stallF, stallD and flushE for one cycle, inserting an E bubble; the consumer then forwards via 01.
REQ-025 Without the macro, a simultaneous pcsrcE and load-use hazard gives flush only, with no stall.

Structure
REQ-026 Package h_fwd_pkg holds the fwd_sel_e enum (FWD_RS=2'b00, FWD_WB=2'b01, FWD_ALU=2'b10, FWD_MEM=2'b11) and the stage_tag_t struct.
REQ-027 Sub-module h_stage_tag is one tag register with hold (stall) and bubble (flush) inputs, instantiated for E, M and W.

Verification
REQ-028 Back-to-back add x5 then sub x6,x5,x1: at sub in E, fa=10 and fb=00.
REQ-029 add x5 with a nop, then or x7,x1,x5: fb=01. Same pattern with rd=x0: fa=fb=00.
REQ-030 With H_FWD_MEMOUT_EN: lw x3 then add x4,x3,x3, memready low for 3 cycles: stalls high for exactly 3 cycles, then fa=fb=11, memerr=0.
REQ-031 Without H_FWD_MEMOUT_EN: same sequence gives one cycle of stallF/stallD/flushE, then fa=fb=01.
REQ-032 pcsrcE=1 with no wait: flushD=flushE=1 for 1 cycle; the next E forward selects are 00.
REQ-033 MEM_TIMEOUT=4 with memready held low for 6 cycles: memerr rises on the 4th wait cycle and stays 1 after memready; rst mid-wait clears all outputs.

Source files
------------

// File: rtl/h_fwd_pkg.sv
// Shared types for the forwarding/hazard controller: operand-select codes, per-stage
// register tag, and the forwarding-source priority function.
package h_fwd_pkg;

   localparam int TAG_AW = 8;

   typedef enum logic [1:0] {
      FWD_RS  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_ALU = 2'b10,
      FWD_MEM = 2'b11
   } fwd_sel_e;

   typedef struct packed {
      logic [TAG_AW-1:0] rs1;
      logic [TAG_AW-1:0] rs2;
      logic [TAG_AW-1:0] rd;
      logic              regwrite;
      logic              load;
   } stage_tag_t;

   localparam stage_tag_t TAG_BUBBLE = '0;

   // M beats W; x0 is hard-wired so never forwards; M load data only when memout_en
   function automatic fwd_sel_e fwd_sel(input logic [TAG_AW-1:0] src,
                                        input stage_tag_t m,
                                        input stage_tag_t w,
                                        input logic memout_en);
      fwd_sel_e sel;
      sel = FWD_RS;
      if (m.regwrite && m.rd == src && m.rd != '0 && !m.load)
         sel = FWD_ALU;
      else if (m.regwrite && m.rd == src && m.rd != '0 && memout_en)
         sel = FWD_MEM;
      else if (w.regwrite && w.rd == src && w.rd != '0)
         sel = FWD_WB;
      return sel;
   endfunction

endpackage

// File: rtl/h_stage_tag.sv
// One pipeline tag register; latency 1 cycle. Backpressure: hold freezes the tag and
// wins over bubble, which loads an empty slot.
module h_stage_tag
   import h_fwd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       hold,
   input  logic       bubble,
   input  stage_tag_t d,
   output stage_tag_t q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= TAG_BUBBLE;
      else if (!hold)
         q <= bubble ? TAG_BUBBLE : d;
   end

endmodule

// File: rtl/h_fwd_ctrl.sv
// Forwarding selects and stall/flush control; selects are combinational from the E/M/W tags.
// Backpressure: a pending M load stalls all stages; H_FWD_MEMOUT_EN forwards load data from M.
module h_fwd_ctrl
   import h_fwd_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int REG_AW      = 5
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] i_data_rs1D,
   input  logic [REG_AW-1:0] i_data_rs2D,
   input  logic [REG_AW-1:0] i_data_rdD,
   input  logic              i_con_regwriteD,
   input  logic              i_con_loadD,
   input  logic              i_con_pcsrcE,
   input  logic              i_con_memready,
   output logic [1:0]        o_con_fa,
   output logic [1:0]        o_con_fb,
   output logic              o_con_stallF,
   output logic              o_con_stallD,
   output logic              o_con_stallE,
   output logic              o_con_stallM,
   output logic              o_con_stallW,
   output logic              o_con_flushD,
   output logic              o_con_flushE,
   output logic              o_con_memerr
);

   localparam int            CW      = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MEM_TIMEOUT);

   stage_tag_t    tag_d, tag_e, tag_m, tag_w;
   logic          memwait, loaduse, flush_e, memout_en;
   logic [CW-1:0] wait_cnt;

   always_comb begin
      tag_d          = TAG_BUBBLE;
      tag_d.rs1      = TAG_AW'(i_data_rs1D);
      tag_d.rs2      = TAG_AW'(i_data_rs2D);
      tag_d.rd       = TAG_AW'(i_data_rdD);
      tag_d.regwrite = i_con_regwriteD;
      tag_d.load     = i_con_loadD;
   end

   assign memwait = tag_m.load && !i_con_memready;

`ifdef H_FWD_MEMOUT_EN
   assign memout_en = 1'b1;
   assign loaduse   = 1'b0;
`else
   assign memout_en = 1'b0;
   assign loaduse   = tag_e.load && tag_e.rd != '0 &&
                      (tag_e.rd == tag_d.rs1 || tag_e.rd == tag_d.rs2);
`endif

   // Memory wait dominates a taken branch, which in turn cancels a load-use stall
   always_comb begin
      o_con_stallF = 1'b0;
      o_con_stallD = 1'b0;
      o_con_stallE = 1'b0;
      o_con_stallM = 1'b0;
      o_con_stallW = 1'b0;
      o_con_flushD = 1'b0;
      flush_e      = 1'b0;
      if (memwait) begin
         o_con_stallF = 1'b1;
         o_con_stallD = 1'b1;
         o_con_stallE = 1'b1;
         o_con_stallM = 1'b1;
         o_con_stallW = 1'b1;
      end else if (i_con_pcsrcE) begin
         o_con_flushD = 1'b1;
         flush_e      = 1'b1;
      end else if (loaduse) begin
         o_con_stallF = 1'b1;
         o_con_stallD = 1'b1;
         flush_e      = 1'b1;
      end
   end

   assign o_con_flushE = flush_e;

   h_stage_tag u_tag_e (.clk(clk), .rst(rst), .hold(memwait), .bubble(flush_e), .d(tag_d), .q(tag_e));
   h_stage_tag u_tag_m (.clk(clk), .rst(rst), .hold(memwait), .bubble(1'b0),    .d(tag_e), .q(tag_m));
   h_stage_tag u_tag_w (.clk(clk), .rst(rst), .hold(memwait), .bubble(1'b0),    .d(tag_m), .q(tag_w));

   assign o_con_fa = fwd_sel(tag_e.rs1, tag_m, tag_w, memout_en);
   assign o_con_fb = fwd_sel(tag_e.rs2, tag_m, tag_w, memout_en);

   // memerr is set by the same edge that brings the saturating count to MEM_TIMEOUT
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt     <= '0;
         o_con_memerr <= 1'b0;
      end else if (memwait) begin
         if (wait_cnt != CNT_MAX)
            wait_cnt <= wait_cnt + CW'(1);
         if (wait_cnt >= CNT_MAX - CW'(1))
            o_con_memerr <= 1'b1;
      end else begin
         wait_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_h_fwd_ctrl.sv
// Scoreboard bench for h_fwd_ctrl: an instruction-level pipeline model predicts every
// cycle's outputs; directed sequences add fixed-value checks.
module tb_h_fwd_ctrl;

   localparam int TO = 4;
`ifdef H_FWD_MEMOUT_EN
   localparam bit MEMOUT = 1'b1;
`else
   localparam bit MEMOUT = 1'b0;
`endif

   typedef struct packed {
      logic [4:0] rs1, rs2, rd;
      logic       rw, ld;
   } ins_t;

   typedef struct packed {
      logic [1:0] fa, fb;
      logic [4:0] stall;
      logic       fd, fe, err;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs1D, rs2D, rdD;
   logic       regwriteD, loadD, pcsrcE, memready;
   logic [1:0] fa, fb;
   logic       stallF, stallD, stallE, stallM, stallW, flushD, flushE, memerr;

   always #5 clk = ~clk;

   h_fwd_ctrl #(.MEM_TIMEOUT(TO), .REG_AW(5)) dut (
      .clk(clk), .rst(rst),
      .i_data_rs1D(rs1D), .i_data_rs2D(rs2D), .i_data_rdD(rdD),
      .i_con_regwriteD(regwriteD), .i_con_loadD(loadD),
      .i_con_pcsrcE(pcsrcE), .i_con_memready(memready),
      .o_con_fa(fa), .o_con_fb(fb),
      .o_con_stallF(stallF), .o_con_stallD(stallD), .o_con_stallE(stallE),
      .o_con_stallM(stallM), .o_con_stallW(stallW),
      .o_con_flushD(flushD), .o_con_flushE(flushE), .o_con_memerr(memerr)
   );

   // Model: in-flight instructions by age (0 = E, 1 = M, 2 = W)
   ins_t pipe [3];
   ins_t d_cur, last_d;
   ins_t prog [$];
   obs_t sbq [$];
   int   wait_run = 0;
   bit   err_m = 1'b0;
   bit   last_rst = 1'b1, last_wait = 1'b0, last_fe = 1'b0, last_sd = 1'b0, last_pc = 1'b0;
   bit   rand_mode = 1'b0;
   int   n_chk = 0, n_fail = 0;

   function automatic ins_t mk(input int a, input int b, input int d, input bit w, input bit l);
      ins_t i;
      i.rs1 = 5'(a); i.rs2 = 5'(b); i.rd = 5'(d); i.rw = w; i.ld = l;
      return i;
   endfunction

   function automatic ins_t rnd();
      ins_t i;
      i.rs1 = 5'($urandom_range(3));
      i.rs2 = 5'($urandom_range(3));
      i.rd  = 5'($urandom_range(3));
      i.rw  = ($urandom_range(3) != 0);
      i.ld  = i.rw && ($urandom_range(2) == 0);
      return i;
   endfunction

   // Where the newest value of register r lives, searching younger producers first
   function automatic logic [1:0] producer(input logic [4:0] r);
      for (int j = 1; j < 3; j++)
         if (pipe[j].rw && pipe[j].rd == r && r != 5'd0)
            return (j == 2) ? 2'b01 : (pipe[j].ld ? 2'b11 : 2'b10);
      return 2'b00;
   endfunction

   task automatic dchk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input bit r, input bit pc, input bit mr);
      obs_t e;
      bit   wt, lu;
      @(posedge clk); #1;
      if (!last_rst) begin
         if (last_wait) begin
            if (wait_run < TO) wait_run++;
            if (wait_run >= TO) err_m = 1'b1;
         end else begin
            wait_run = 0;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = last_fe ? ins_t'(0) : last_d;
         end
      end
      if (!last_sd)
         d_cur = (prog.size() != 0) ? prog.pop_front() : (rand_mode ? rnd() : ins_t'(0));
      if (r) begin
         foreach (pipe[j]) pipe[j] = '0;
         wait_run = 0;
         err_m = 1'b0;
      end
      rst = r; pcsrcE = pc; memready = mr;
      rs1D = d_cur.rs1; rs2D = d_cur.rs2; rdD = d_cur.rd;
      regwriteD = d_cur.rw; loadD = d_cur.ld;
      wt = pipe[1].ld && !mr;
      lu = !MEMOUT && pipe[0].ld && pipe[0].rd != 5'd0 &&
           (pipe[0].rd == d_cur.rs1 || pipe[0].rd == d_cur.rs2);
      e = '0;
      e.fa  = producer(pipe[0].rs1);
      e.fb  = producer(pipe[0].rs2);
      e.err = err_m;
      if (wt) e.stall = 5'b11111;
      else if (pc) begin e.fd = 1'b1; e.fe = 1'b1; end
      else if (lu) begin e.stall = 5'b11000; e.fe = 1'b1; end
      sbq.push_back(e);
      last_rst = r; last_wait = wt; last_fe = e.fe; last_sd = e.stall[3];
      last_d = d_cur; last_pc = pc;
      #3;
   endtask

   task automatic drain(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b1);
   endtask

   // Monitor: one expected record per cycle, compared mid-cycle
   initial begin
      obs_t exp_o, act_o;
      forever begin
         @(negedge clk);
         if (sbq.size() != 0) begin
            exp_o = sbq.pop_front();
            act_o = {fa, fb, stallF, stallD, stallE, stallM, stallW, flushD, flushE, memerr};
            n_chk++;
            if (act_o !== exp_o) begin
               n_fail++;
               $display("FAIL scoreboard t=%0t: got fa=%b fb=%b stall=%b flD=%b flE=%b err=%b, expected fa=%b fb=%b stall=%b flD=%b flE=%b err=%b",
                        $time, act_o.fa, act_o.fb, act_o.stall, act_o.fd, act_o.fe, act_o.err,
                        exp_o.fa, exp_o.fb, exp_o.stall, exp_o.fd, exp_o.fe, exp_o.err);
            end
         end
      end
   end

   initial begin
      bit r, pc, mr;
      foreach (pipe[j]) pipe[j] = '0;
      d_cur = '0; last_d = '0;
      rst = 1'b1; pcsrcE = 1'b0; memready = 1'b1;
      rs1D = '0; rs2D = '0; rdD = '0; regwriteD = 1'b0; loadD = 1'b0;

      step(1, 0, 1);
      dchk("reset_fwd", 32'({fa, fb}), 32'h0);
      dchk("reset_ctl", 32'({stallF, stallD, stallE, stallM, stallW, flushD, flushE}), 32'h0);
      dchk("reset_memerr", 32'(memerr), 32'h0);
      step(1, 0, 1);

      // add x5 ; sub x6,x5,x1
      prog.push_back(mk(1, 2, 5, 1, 0));
      prog.push_back(mk(5, 1, 6, 1, 0));
      drain(3);
      dchk("b2b_fa", 32'(fa), 32'h2);
      dchk("b2b_fb", 32'(fb), 32'h0);
      drain(3);

      // add x5 ; nop ; or x7,x1,x5
      prog.push_back(mk(1, 2, 5, 1, 0));
      prog.push_back(mk(0, 0, 0, 0, 0));
      prog.push_back(mk(1, 5, 7, 1, 0));
      drain(4);
      dchk("wb_fa", 32'(fa), 32'h0);
      dchk("wb_fb", 32'(fb), 32'h1);
      drain(3);

      // same with rd = x0
      prog.push_back(mk(1, 2, 0, 1, 0));
      prog.push_back(mk(0, 0, 0, 0, 0));
      prog.push_back(mk(0, 0, 7, 1, 0));
      drain(4);
      dchk("x0_fwd", 32'({fa, fb}), 32'h0);
      drain(3);

      // lw x3 ; add x4,x3,x3 with three memory-wait cycles
      prog.push_back(mk(1, 0, 3, 1, 1));
      prog.push_back(mk(3, 3, 4, 1, 0));
      step(0, 0, 1);
      step(0, 0, 1);
      dchk("loaduse_ctl", 32'({stallF, stallD, stallE, stallM, stallW, flushD, flushE}),
           MEMOUT ? 32'h0 : 32'(7'b1100001));
      repeat (3) begin
         step(0, 0, 0);
         dchk("memwait_stall", 32'({stallF, stallD, stallE, stallM, stallW}), 32'h1f);
         dchk("memwait_flush", 32'({flushD, flushE}), 32'h0);
      end
      step(0, 0, 1);
      dchk("waitend_stall", 32'({stallF, stallD, stallE, stallM, stallW}), 32'h0);
      dchk("waitend_fwd", 32'({fa, fb}), MEMOUT ? 32'hf : 32'h0);
      dchk("waitend_memerr", 32'(memerr), 32'h0);
      step(0, 0, 1);
      dchk("after_fwd", 32'({fa, fb}), MEMOUT ? 32'h0 : 32'h5);
      drain(3);

      // taken branch
      prog.push_back(mk(1, 2, 5, 1, 0));
      prog.push_back(mk(5, 5, 6, 1, 0));
      step(0, 0, 1);
      step(0, 1, 1);
      dchk("branch_flush", 32'({flushD, flushE}), 32'h3);
      dchk("branch_stall", 32'({stallF, stallD, stallE, stallM, stallW}), 32'h0);
      step(0, 0, 1);
      dchk("post_branch_flush", 32'({flushD, flushE}), 32'h0);
      dchk("post_branch_fwd", 32'({fa, fb}), 32'h0);
      drain(3);

      // memory timeout: six wait cycles
      prog.push_back(mk(1, 0, 3, 1, 1));
      step(0, 0, 1);
      step(0, 0, 1);
      for (int k = 1; k <= 6; k++) begin
         step(0, 0, 0);
         dchk($sformatf("timeout_wait%0d_memerr", k), 32'(memerr), (k > TO) ? 32'h1 : 32'h0);
         dchk("timeout_stall", 32'({stallF, stallD, stallE, stallM, stallW}), 32'h1f);
      end
      step(0, 0, 1);
      dchk("timeout_sticky", 32'(memerr), 32'h1);
      dchk("timeout_release", 32'({stallF, stallD, stallE, stallM, stallW}), 32'h0);
      drain(3);

      // reset in the middle of a wait
      prog.push_back(mk(1, 0, 3, 1, 1));
      step(0, 0, 1);
      step(0, 0, 1);
      step(0, 0, 0);
      dchk("prerst_stall", 32'({stallF, stallD, stallE, stallM, stallW}), 32'h1f);
      step(1, 0, 0);
      dchk("midrst_all", 32'({fa, fb, stallF, stallD, stallE, stallM, stallW, flushD, flushE, memerr}), 32'h0);
      step(0, 0, 1);

      // randomized traffic
      rand_mode = 1'b1;
      repeat (3000) begin
         r  = ($urandom_range(199) == 0);
         pc = last_wait ? last_pc : ($urandom_range(7) == 0);
         mr = ($urandom_range(3) != 0);
         step(r, pc, mr);
      end
      rand_mode = 1'b0;
      drain(2);
      @(negedge clk); #1;
      dchk("scoreboard_empty", 32'(sbq.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
